pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
- REQ-001: The block SHALL have a parameter NSTAGE, default 5, giving the number of pipeline registers R[0..NSTAGE-1]. R[0] is the PC register; stage s logic reads R[s] and produces R[s+1].
- REQ-002: The block SHALL have a parameter REDIR_STAGE, default 1, giving the stage whose logic resolves control-flow redirects.
- REQ-003: The block SHALL have a parameter CNT_W, default 64, giving the width of the performance counters.
- REQ-004: clk, input, 1 bit: the single clock; all state updates on the rising edge.
- REQ-005: reset, input, 1 bit: asynchronous, active-high reset.
- REQ-006: stage_wait, input, NSTAGE bits: bit s is high when stage s logic is busy (memory wait, multi-cycle execute, load-use hazard).
- REQ-007: redirect, input, 1 bit: stage REDIR_STAGE has found a taken branch or jump.
- REQ-008: stage_en, output, NSTAGE bits: register R[s] loads this cycle.
- REQ-009: stage_flush, output, NSTAGE bits: R[s] loads a bubble instead of its producer output; asserted only together with stage_en[s].
- REQ-010: stage_valid, output, NSTAGE bits: R[s] holds a live instruction.
- REQ-011: pc_sel, output, 1 bit: R[0] loads the redirect target instead of the predicted PC.
- REQ-012: commit, output, 1 bit: the instruction in R[NSTAGE-1] retires this cycle.
- REQ-013: cycle_cnt, output, CNT_W bits: cycles elapsed since reset.
- REQ-014: instr_cnt, output, CNT_W bits: instructions retired since reset.
- REQ-015: Legal parameters SHALL be NSTAGE >= 3 and 1 <= REDIR_STAGE <= NSTAGE-2. Illegal values are a simulation-time fatal error.

Function
- REQ-016: hold[s] SHALL be the OR of stage_wait[NSTAGE-1:s].
- REQ-017: stage_en[s] SHALL be !hold[s], combinationally.
- REQ-018: For s >= 1, stage_flush[s] SHALL be high when hold[s-1] && !hold[s] (bubble insertion below the stalled stage). stage_flush[0] SHALL always be 0.
- REQ-019: pc_sel SHALL be redirect && !hold[REDIR_STAGE]. A redirect arriving while its stage is held is ignored; the source keeps redirect asserted until accepted.
- REQ-020: When pc_sel is high, stage_flush[s] SHALL be high for s = 1..REDIR_STAGE (wrong-path squash). The redirecting instruction itself advances normally to R[REDIR_STAGE+1].
- REQ-021: If a flush and a bubble apply to the same register in the same cycle, the result SHALL be a single bubble; no other effect.
- REQ-022: stage_valid update on each edge:
  - stage_valid[0] SHALL be 1 from the first edge after reset release.
  - For s >= 1: if stage_en[s] && stage_flush[s], then 0.
  - Else if stage_en[s], then stage_valid[s-1].
  - Else unchanged.
- REQ-023: commit SHALL be stage_valid[NSTAGE-1] && !stage_wait[NSTAGE-1], combinationally, with zero added latency.
- REQ-024: cycle_cnt SHALL increment by 1 every edge after reset release, wrapping modulo 2^CNT_W.
- REQ-025: instr_cnt SHALL increment by 1 on each edge where commit is high, wrapping modulo 2^CNT_W.
- REQ-026: With all stage_wait bits high, all stage_en bits SHALL be 0 and no state changes except cycle_cnt.

Reset
- REQ-027: While reset is high, stage_valid, cycle_cnt and instr_cnt SHALL be 0 immediately, without waiting for a clock edge.
- REQ-028: While reset is high, pc_sel and commit SHALL be 0, and stage_en and stage_flush SHALL follow REQ-017/018 from the inputs.
- REQ-029: Reset asserted mid-operation SHALL discard all in-flight valid state with no commit. The first commit after release SHALL be no earlier than NSTAGE-1 edges after release.

Configuration
- REQ-030: Macro PIPE_PERF_CNT_EN, when defined, SHALL implement cycle_cnt and instr_cnt as specified.
- REQ-031: When PIPE_PERF_CNT_EN is undefined, cycle_cnt and instr_cnt SHALL be constant 0 with no counter flops. All other behaviour is unchanged.

Verification (NSTAGE=5, REDIR_STAGE=1, PIPE_PERF_CNT_EN defined)
- REQ-032: Release reset, stage_wait=0, redirect=0.
  - Required: stage_valid reaches 5'b11111 after the 5th edge.
  - Required: commit is first high after the 5th edge.
  - Required: instr_cnt=1 and cycle_cnt=6 after the 6th edge.
- REQ-033: Full pipeline, stage_wait=5'b01000 for 3 cycles.
  - Required: stage_en=5'b10000 and stage_flush=5'b10000 in each of those cycles.
  - Required: stage_valid[4]=0 after the first edge.
  - Required: instr_cnt rises by 1 over the 3 cycles (the first of them only).
- REQ-034: Full pipeline, redirect=1 for 1 cycle, no waits.
  - Required: pc_sel=1, stage_en=5'b11111, stage_flush=5'b00010.
  - Required: next cycle stage_valid[1]=0 and stage_valid[2]=1.
- REQ-035: redirect=1 with stage_wait=5'b00100 for 2 cycles, then wait released.
  - Required: pc_sel=0 and stage_flush=5'b01000 during the wait.
  - Required: pc_sel=1 and stage_flush=5'b00010 in the first cycle after release.
- REQ-036: Full pipeline, stage_wait=5'b11111 for 4 cycles.
  - Required: stage_en=0 and commit=0 throughout.
  - Required: stage_valid unchanged, cycle_cnt +4, instr_cnt unchanged.
- REQ-037: Assert reset between edges with the pipeline full and counters nonzero.
  - Required: stage_valid=0, cycle_cnt=0, instr_cnt=0 before the next edge.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between pipe_ctrl and the datapath it steers.
// master drives waits/redirect and observes controls; slave is pipe_ctrl.
interface pipe_ctrl_if #(
   parameter int NSTAGE = 5,
   parameter int CNT_W  = 64
);
   logic [NSTAGE-1:0] stage_wait;
   logic              redirect;
   logic [NSTAGE-1:0] stage_en;
   logic [NSTAGE-1:0] stage_flush;
   logic [NSTAGE-1:0] stage_valid;
   logic              pc_sel;
   logic              commit;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [CNT_W-1:0]  instr_cnt;

   modport master (
      output stage_wait, redirect,
      input  stage_en, stage_flush, stage_valid, pc_sel, commit,
             cycle_cnt, instr_cnt
   );

   modport slave (
      input  stage_wait, redirect,
      output stage_en, stage_flush, stage_valid, pc_sel, commit,
             cycle_cnt, instr_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// In-order pipeline controller: stall propagation, bubble insertion, redirect squash.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
   parameter int NSTAGE      = 5,
   parameter int REDIR_STAGE = 1,
   parameter int CNT_W       = 64
) (
   input  logic      clk,
   input  logic      reset,
   pipe_ctrl_if.slave bus
);

   generate
      if (NSTAGE < 3 || REDIR_STAGE < 1 || REDIR_STAGE > NSTAGE - 2) begin : g_bad_param
         $fatal(1, "pipe_ctrl: illegal NSTAGE/REDIR_STAGE combination");
      end
   endgenerate

   logic [NSTAGE-1:0] w_hold;
   logic [NSTAGE-1:0] w_en;
   logic [NSTAGE-1:0] w_flush;
   logic              w_pc_sel;
   logic              w_commit;
   logic [NSTAGE-1:0] r_valid;

   // A stall anywhere downstream freezes every register at or above it.
   always_comb begin
      w_hold             = '0;
      w_hold[NSTAGE-1]   = bus.stage_wait[NSTAGE-1];
      for (int s = NSTAGE - 2; s >= 0; s--) begin
         w_hold[s] = bus.stage_wait[s] | w_hold[s+1];
      end
   end

   assign w_en     = ~w_hold;
   assign w_pc_sel = bus.redirect & ~w_hold[REDIR_STAGE] & ~reset;
   assign w_commit = r_valid[NSTAGE-1] & ~bus.stage_wait[NSTAGE-1] & ~reset;

   // Bubble below the stall boundary and wrong-path squash merge into one flush.
   always_comb begin
      w_flush = '0;
      for (int s = 1; s < NSTAGE; s++) begin
         w_flush[s] = w_en[s] & (w_hold[s-1] | (w_pc_sel & (s <= REDIR_STAGE)));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
      end else begin
         r_valid[0] <= 1'b1;
         for (int s = 1; s < NSTAGE; s++) begin
            if (w_en[s]) begin
               r_valid[s] <= w_flush[s] ? 1'b0 : r_valid[s-1];
            end
         end
      end
   end

   assign bus.stage_en    = w_en;
   assign bus.stage_flush = w_flush;
   assign bus.stage_valid = r_valid;
   assign bus.pc_sel      = w_pc_sel;
   assign bus.commit      = w_commit;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_instr_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         if (w_commit) begin
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.cycle_cnt = r_cycle_cnt;
   assign bus.instr_cnt = r_instr_cnt;
`else
   assign bus.cycle_cnt = '0;
   assign bus.instr_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl against a cycle-level reference model.
module tb_pipe_ctrl;
   localparam int N  = 5;
   localparam int RS = 1;
   localparam int CW = 64;

   logic clk = 1'b0;
   logic reset;

   pipe_ctrl_if #(.NSTAGE(N), .CNT_W(CW)) bus ();

   pipe_ctrl #(.NSTAGE(N), .REDIR_STAGE(RS), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tot  = 0;
   int n_pass = 0;
   int n_fail = 0;

   bit              m_v [N];
   longint unsigned m_cyc;
   longint unsigned m_ins;

   logic [N-1:0] s_en, s_flush;
   logic         s_pc, s_commit;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] mvalid();
      logic [N-1:0] v;
      for (int s = 0; s < N; s++) v[s] = m_v[s];
      return v;
   endfunction

   function automatic longint unsigned cexp(input longint unsigned v);
`ifdef PIPE_PERF_CNT_EN
      return v;
`else
      return 0;
`endif
   endfunction

   // One clock cycle: apply inputs, compare at the falling edge, advance the model at the rising edge.
   task automatic cyc(input logic [N-1:0] w, input bit r, input bit rst);
      bit           hold [N];
      logic [N-1:0] e_en, e_fl, nv;
      bit           e_pc, e_cm;
      bus.stage_wait = w;
      bus.redirect   = r;
      reset          = rst;
      if (rst) begin
         for (int s = 0; s < N; s++) m_v[s] = 1'b0;
         m_cyc = 0;
         m_ins = 0;
      end
      for (int s = 0; s < N; s++) hold[s] = ((w >> s) != 0);
      for (int s = 0; s < N; s++) e_en[s] = !hold[s];
      e_pc = !rst && r && !hold[RS];
      e_fl = '0;
      for (int s = 1; s < N; s++) e_fl[s] = e_en[s] && (hold[s-1] || (e_pc && s <= RS));
      e_cm = !rst && m_v[N-1] && !w[N-1];
      @(negedge clk);
      s_en     = bus.stage_en;
      s_flush  = bus.stage_flush;
      s_pc     = bus.pc_sel;
      s_commit = bus.commit;
      chk("stage_en", s_en, e_en);
      chk("stage_flush", s_flush, e_fl);
      chk("pc_sel", s_pc, e_pc);
      chk("commit", s_commit, e_cm);
      chk("stage_valid", bus.stage_valid, mvalid());
      chk("cycle_cnt", bus.cycle_cnt, cexp(m_cyc));
      chk("instr_cnt", bus.instr_cnt, cexp(m_ins));
      @(posedge clk);
      if (!rst) begin
         nv[0] = 1'b1;
         for (int s = 1; s < N; s++) nv[s] = e_en[s] ? (e_fl[s] ? 1'b0 : m_v[s-1]) : m_v[s];
         for (int s = 0; s < N; s++) m_v[s] = nv[s];
         m_cyc++;
         if (e_cm) m_ins++;
      end
      #1;
   endtask

   initial begin
      logic [N-1:0]    v0;
      longint unsigned c0, i0;
      logic [N-1:0]    rw;

      bus.stage_wait = '0;
      bus.redirect   = 1'b0;
      reset          = 1'b1;
      #1;
      chk("rst_valid", bus.stage_valid, 0);
      chk("rst_cycle", bus.cycle_cnt, 0);
      chk("rst_instr", bus.instr_cnt, 0);
      cyc('0, 1'b0, 1'b1);

      // Fill from reset release.
      for (int k = 1; k <= 6; k++) begin
         cyc('0, 1'b0, 1'b0);
         chk("fill_commit", s_commit, (k == 6));
         if (k == 5) chk("fill_valid", bus.stage_valid, 5'b11111);
      end
      chk("fill_instr", bus.instr_cnt, cexp(1));
      chk("fill_cycle", bus.cycle_cnt, cexp(6));

      // Mid-pipe stall at stage 3.
      i0 = m_ins;
      for (int k = 0; k < 3; k++) begin
         cyc(5'b01000, 1'b0, 1'b0);
         chk("stall_en", s_en, 5'b10000);
         chk("stall_flush", s_flush, 5'b10000);
         if (k == 0) chk("stall_v4", bus.stage_valid[4], 1'b0);
      end
      chk("stall_instr", bus.instr_cnt, cexp(i0 + 1));
      repeat (3) cyc('0, 1'b0, 1'b0);

      // Redirect accepted immediately.
      cyc('0, 1'b1, 1'b0);
      chk("redir_pc", s_pc, 1'b1);
      chk("redir_en", s_en, 5'b11111);
      chk("redir_flush", s_flush, 5'b00010);
      chk("redir_v1", bus.stage_valid[1], 1'b0);
      chk("redir_v2", bus.stage_valid[2], 1'b1);
      repeat (4) cyc('0, 1'b0, 1'b0);

      // Redirect held off by a stall below it.
      repeat (2) begin
         cyc(5'b00100, 1'b1, 1'b0);
         chk("hredir_pc", s_pc, 1'b0);
         chk("hredir_flush", s_flush, 5'b01000);
      end
      cyc('0, 1'b1, 1'b0);
      chk("hredir_pc_rel", s_pc, 1'b1);
      chk("hredir_flush_rel", s_flush, 5'b00010);
      repeat (5) cyc('0, 1'b0, 1'b0);

      // Full freeze.
      v0 = mvalid();
      c0 = m_cyc;
      i0 = m_ins;
      repeat (4) begin
         cyc(5'b11111, 1'($urandom_range(0, 1)), 1'b0);
         chk("freeze_en", s_en, 0);
         chk("freeze_commit", s_commit, 0);
      end
      chk("freeze_valid", bus.stage_valid, v0);
      chk("freeze_cycle", bus.cycle_cnt, cexp(c0 + 4));
      chk("freeze_instr", bus.instr_cnt, cexp(i0));

      // Asynchronous reset between edges.
      repeat (3) cyc('0, 1'b0, 1'b0);
      reset = 1'b1;
      #2;
      chk("areset_valid", bus.stage_valid, 0);
      chk("areset_cycle", bus.cycle_cnt, 0);
      chk("areset_instr", bus.instr_cnt, 0);
      repeat (2) cyc('0, 1'b0, 1'b1);

      // Randomized traffic with occasional resets.
      repeat (400) begin
         for (int s = 0; s < N; s++) rw[s] = ($urandom_range(0, 5) == 0);
         cyc(rw, ($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
